axis_packet_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares one AXI-Stream master port between NUM_SRC AXI-Stream slave sources. Typical sources are the read sides of per-channel async FIFO stream bridges.
- Once a source is granted, it holds the grant until its TLAST beat is accepted. Packets are never interleaved.
- Provides per-source enables, a maximum-packet-length guard, and status outputs for software/debug.

---
 rtl/axis_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/axis_packet_arbiter.sv | 144 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
//   arb_state_e      : arbiter FSM states (IDLE waits for a request, XFER
//                      passes one packet through)
//   PKT_CNT_W        : width of the completed-packet counter
//   beat_cnt_width() : width needed to hold a beat count up to max_beats
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int PKT_CNT_W = 16;

  function automatic int beat_cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
//   req        : request vector, one bit per requester
//   last_grant : index of the previously served requester
//   gnt_valid  : at least one request is pending
//   gnt_id     : first requester found scanning upward from last_grant+1,
//                wrapping modulo NUM_SRC
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  logic [ID_W-1:0] idx;

  // The scan starts one past last_grant, so the previous winner is checked
  // last and gets the lowest priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = ID_W'((int'(last_grant) + off) % NUM_SRC);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SRC AXI-Stream slaves share one
// AXI-Stream master. A granted source keeps the grant until its TLAST beat is
// accepted; a packet reaching MAX_PKT_BEATS is cut with a forced TLAST.
//   ACLK, ARESETn          : clock, asynchronous active-low reset
//   S_AXIS_T*              : per-source slave streams (data packed by source)
//   M_AXIS_T*              : shared master stream, combinational pass-through
//   src_enable             : per-source eligibility for new grants
//   grant_id               : current / most recent granted source
//   busy                   : a packet is in flight
//   pkt_count              : completed packets, wrapping
//   overflow               : sticky, a forced TLAST has occurred
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_SRC       = 4,
  parameter int MAX_PKT_BEATS = 1024,
  parameter int ID_W          = $clog2(NUM_SRC)
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
  input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
  output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic                          M_AXIS_TVALID,
  output logic [DATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY,
  input  logic [NUM_SRC-1:0]            src_enable,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [PKT_CNT_W-1:0]          pkt_count,
  output logic                          overflow
);

  localparam int BCW = beat_cnt_width(MAX_PKT_BEATS);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [BCW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic                 overflow_q, overflow_d;

  logic [NUM_SRC-1:0]   req;
  logic                 gnt_valid;
  logic [ID_W-1:0]      gnt_id;
  logic                 in_xfer;
  logic                 src_last;
  logic                 max_hit;
  logic                 beat_acc;
  logic                 pkt_end;

  // src_enable only matters here, i.e. for choosing the next packet owner.
  assign req = S_AXIS_TVALID & src_enable;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Datapath: zero-latency mux from the granted source to the master port.
  always_comb begin
    in_xfer       = (state_q == XFER);
    src_last      = S_AXIS_TLAST[grant_id_q];
    max_hit       = (beat_cnt_q == BCW'(MAX_PKT_BEATS - 1));
    M_AXIS_TDATA  = S_AXIS_TDATA[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    M_AXIS_TVALID = in_xfer & S_AXIS_TVALID[grant_id_q];
    M_AXIS_TLAST  = in_xfer & (src_last | max_hit);
    S_AXIS_TREADY = '0;
    if (in_xfer) begin
      S_AXIS_TREADY[grant_id_q] = M_AXIS_TREADY;
    end
    beat_acc = M_AXIS_TVALID & M_AXIS_TREADY;
    pkt_end  = beat_acc & M_AXIS_TLAST;
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_count_d  = pkt_count_q;
    overflow_d   = overflow_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = XFER;
          grant_id_d = gnt_id;
          beat_cnt_d = '0;
        end
      end
      XFER: begin
        if (pkt_end) begin
          state_d      = IDLE;
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
          pkt_count_d  = pkt_count_q + 1'b1;
          // A cut made only by the length guard leaves the rest of the source
          // packet to be arbitrated again as a new packet.
          if (max_hit && !src_last) begin
            overflow_d = 1'b1;
          end
        end else if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      pkt_count_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_count_q  <= pkt_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign M_AXIS_TSTRB = '1;
  assign grant_id     = grant_id_q;
  assign busy         = in_xfer;
  assign pkt_count    = pkt_count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;

  localparam int DW   = 32;
  localparam int NS   = 4;
  localparam int MAXB = 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NS*DW-1:0] s_tdata = '0;
  logic [NS-1:0]   s_tvalid = '0;
  logic [NS-1:0]   s_tlast = '0;
  logic [NS-1:0]   s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic [DW/8-1:0] m_tstrb;
  logic            m_tlast;
  logic            m_tready = 1'b1;
  logic [NS-1:0]   src_en = '1;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     pkt_count;
  logic            overflow;

  int n_chk  = 0;
  int n_fail = 0;

  // Per-source beat queues {last, data} and the expected master output stream.
  logic [DW:0] src_q [NS][$];
  logic [DW:0] exp_q [$];

  always #5 aclk = ~aclk;

  axis_packet_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_SRC       (NS),
    .MAX_PKT_BEATS (MAXB)
  ) dut (
    .ACLK          (aclk),
    .ARESETn       (aresetn),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TREADY (s_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready),
    .src_enable    (src_en),
    .grant_id      (grant_id),
    .busy          (busy),
    .pkt_count     (pkt_count),
    .overflow      (overflow)
  );

  function automatic logic [DW-1:0] beat_word(input int src, input int tag, input int b);
    return {8'(src), 8'(tag), 16'(b)};
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]          = 1'b1;
        s_tlast[i]           = src_q[i][0][DW];
        s_tdata[i*DW +: DW]  = src_q[i][0][DW-1:0];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tlast[i]           = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
      end
    end
  endtask

  // Source side: one packet of n beats, TLAST on the final beat.
  task automatic load_pkt(input int src, input int tag, input int n);
    for (int b = 0; b < n; b++) src_q[src].push_back({(b == n - 1), beat_word(src, tag, b)});
  endtask

  // Expected master side: the length guard cuts every MAXB beats.
  task automatic push_exp(input int src, input int tag, input int n);
    int seg = 0;
    for (int b = 0; b < n; b++) begin
      logic lst;
      seg++;
      lst = (b == n - 1) || (seg == MAXB);
      if (lst) seg = 0;
      exp_q.push_back({lst, beat_word(src, tag, b)});
    end
  endtask

  // One clock: sample at the falling edge, then advance sources past the
  // rising edge according to the handshakes seen.
  task automatic step(output logic mfire, output logic mvalid, output logic [DW-1:0] mdata,
                      output logic mlast, output logic [NS-1:0] sready);
    logic [NS-1:0] fired;
    @(negedge aclk);
    mvalid = m_tvalid;
    mfire  = m_tvalid & m_tready;
    mdata  = m_tdata;
    mlast  = m_tlast;
    sready = s_tready;
    fired  = s_tready & s_tvalid;
    @(posedge aclk);
    #1;
    for (int i = 0; i < NS; i++) if (fired[i]) void'(src_q[i].pop_front());
    drive_srcs();
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = {NS*DW/4{4'hA}};
    m_tready = 1'b1;
    src_en   = '1;
    repeat (3) @(posedge aclk);
    #1;
    n_chk++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL reset_tready: got %b expected 0000", s_tready); end
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
    n_chk++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b expected 0", m_tlast); end
    n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_chk++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_chk++; if (m_tstrb !== 4'hF) begin n_fail++; $display("FAIL reset_tstrb: got %h expected f", m_tstrb); end
    drive_srcs();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_all_sources();
    logic mf, mv, ml, prev_end;
    logic [DW-1:0] md;
    logic [NS-1:0] sr;
    logic [DW:0] e;
    prev_end = 1'b0;
    m_tready = 1'b1;
    for (int s = 0; s < NS; s++) begin
      load_pkt(s, 1, 3);
      push_exp(s, 1, 3);
    end
    drive_srcs();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      step(mf, mv, md, ml, sr);
      if (c == 0) begin
        n_chk++; if (mv !== 1'b0) begin n_fail++; $display("FAIL arb_latency_c0: got tvalid %b expected 0", mv); end
      end
      if (c == 1) begin
        n_chk++; if (mv !== 1'b1) begin n_fail++; $display("FAIL arb_latency_c1: got tvalid %b expected 1", mv); end
      end
      if (prev_end) begin
        n_chk++; if (mv !== 1'b0) begin n_fail++; $display("FAIL idle_gap: got tvalid %b expected 0 after tlast", mv); end
      end
      prev_end = mf & ml;
      if (mf) begin
        e = exp_q.pop_front();
        n_chk++; if ({ml, md} !== e) begin n_fail++; $display("FAIL rr_beat: got %h expected %h", {ml, md}, e); end
      end
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_timeout: got %0d beats left expected 0", exp_q.size()); exp_q.delete(); end
    step(mf, mv, md, ml, sr);
    n_chk++; if (pkt_count !== 16'd4) begin n_fail++; $display("FAIL rr_pkt_count: got %0d expected 4", pkt_count); end
  endtask

  task automatic test_backpressure();
    logic mf, mv, ml, done2;
    logic [DW-1:0] md;
    logic [NS-1:0] sr;
    logic [DW:0] e;
    done2 = 1'b0;
    load_pkt(2, 2, 5);
    push_exp(2, 2, 5);
    drive_srcs();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      m_tready = (c % 2 == 0);
      if (c == 3) begin
        load_pkt(1, 2, 2);
        push_exp(1, 2, 2);
        drive_srcs();
      end
      step(mf, mv, md, ml, sr);
      if (!done2) begin
        n_chk++; if (sr[1] !== 1'b0) begin n_fail++; $display("FAIL bp_src1_ready: got %b expected 0", sr[1]); end
      end
      if (mf) begin
        e = exp_q.pop_front();
        n_chk++; if ({ml, md} !== e) begin n_fail++; $display("FAIL bp_beat: got %h expected %h", {ml, md}, e); end
        if (md[31:24] == 8'd2 && ml) done2 = 1'b1;
      end
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d beats left expected 0", exp_q.size()); exp_q.delete(); end
    m_tready = 1'b1;
    step(mf, mv, md, ml, sr);
  endtask

  task automatic test_src_enable();
    logic mf, mv, ml;
    logic [DW-1:0] md;
    logic [NS-1:0] sr;
    logic [DW:0] e;
    int order [6];
    order = '{3, 0, 1, 3, 0, 1};
    src_en   = 4'b1011;
    m_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      load_pkt(0, 3 + k, 2);
      load_pkt(1, 3 + k, 2);
      load_pkt(3, 3 + k, 2);
    end
    load_pkt(2, 3, 2);
    // Last grant before this test was source 1, so source 3 is next.
    for (int k = 0; k < 6; k++) push_exp(order[k], 3 + k / 3, 2);
    drive_srcs();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      step(mf, mv, md, ml, sr);
      n_chk++; if (sr[2] !== 1'b0) begin n_fail++; $display("FAIL en_src2_ready: got %b expected 0", sr[2]); end
      if (mf) begin
        e = exp_q.pop_front();
        n_chk++; if ({ml, md} !== e) begin n_fail++; $display("FAIL en_beat: got %h expected %h", {ml, md}, e); end
      end
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL en_timeout: got %0d beats left expected 0", exp_q.size()); exp_q.delete(); end
    step(mf, mv, md, ml, sr);
    n_chk++; if (s_tready[2] !== 1'b0) begin n_fail++; $display("FAIL en_src2_idle: got %b expected 0", s_tready[2]); end
    src_q[2].delete();
    drive_srcs();
    src_en = 4'b1111;
  endtask

  task automatic test_overflow();
    logic mf, mv, ml;
    logic [DW-1:0] md;
    logic [NS-1:0] sr;
    logic [DW:0] e;
    logic [15:0] pc0;
    pc0 = pkt_count;
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    m_tready = 1'b1;
    load_pkt(0, 5, 10);
    push_exp(0, 5, 10);
    drive_srcs();
    for (int c = 0; c < 200; c++) begin
      if (exp_q.size() == 0) break;
      step(mf, mv, md, ml, sr);
      if (mf) begin
        e = exp_q.pop_front();
        n_chk++; if ({ml, md} !== e) begin n_fail++; $display("FAIL ovf_beat: got %h expected %h", {ml, md}, e); end
      end
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_timeout: got %0d beats left expected 0", exp_q.size()); exp_q.delete(); end
    step(mf, mv, md, ml, sr);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_chk++; if (pkt_count !== pc0 + 16'd2) begin n_fail++; $display("FAIL ovf_pkt_count: got %0d expected %0d", pkt_count, pc0 + 16'd2); end
  endtask

  task automatic test_reset_mid_packet();
    logic mf, mv, ml;
    logic [DW-1:0] md;
    logic [NS-1:0] sr;
    logic [DW:0] e;
    m_tready = 1'b1;
    load_pkt(1, 6, 6);
    drive_srcs();
    for (int c = 0; c < 20; c++) begin
      if (src_q[1].size() == 5) break;
      step(mf, mv, md, ml, sr);
    end
    n_chk++; if (src_q[1].size() != 5) begin n_fail++; $display("FAIL rst_mid_start: got %0d beats left expected 5", src_q[1].size()); end
    n_chk++; if (m_tvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_beat2: got tvalid %b expected 1", m_tvalid); end
    #2;
    aresetn = 1'b0;
    #1;
    n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid: got %b expected 0", m_tvalid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_chk++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_pkt_count: got %0d expected 0", pkt_count); end
    n_chk++; if (s_tready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_tready: got %b expected 0000", s_tready); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < NS; i++) src_q[i].delete();
    drive_srcs();
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    load_pkt(3, 7, 2);
    load_pkt(0, 7, 2);
    push_exp(0, 7, 2);
    push_exp(3, 7, 2);
    drive_srcs();
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0) break;
      step(mf, mv, md, ml, sr);
      if (mf) begin
        e = exp_q.pop_front();
        n_chk++; if ({ml, md} !== e) begin n_fail++; $display("FAIL rst_after_beat: got %h expected %h", {ml, md}, e); end
      end
    end
    n_chk++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_after_timeout: got %0d beats left expected 0", exp_q.size()); exp_q.delete(); end
    step(mf, mv, md, ml, sr);
    n_chk++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL rst_after_pkt_count: got %0d expected 2", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_all_sources();
    test_backpressure();
    test_src_enable();
    test_overflow();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
